timer_seq_master: RTL

Hardware Avalon-MM initiator that programs and services the 16-bit register-mapped interval timer without CPU involvement. It sits between a local command source (DMA sequencer or state machine) and the timer's s1 slave port. It converts single commands (arm one-shot, arm continuous, stop, snapshot) into the timer's register write/read sequences. It polls or follows `irq` for completion and returns a 32-bit response.

---
 rtl/timer_seq_master.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/timer_seq_master.sv
// Avalon-MM initiator that drives a 16-bit interval timer's s1 port: it turns
// arm/stop/snapshot commands into register sequences and reports completion.
module timer_seq_master #(
    parameter int POLL_GAP = 16,
    parameter bit IRQ_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_period,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_timeout
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CLR, S_WR_CTL, S_WAIT, S_RD_ST, S_CAP_ST,
        S_WR_ACK, S_WR_STOP, S_SN_WR, S_SN_RDL, S_SN_RDH, S_SN_CAP, S_RESP
    } state_t;

    localparam logic [7:0] GAP_M1 = 8'(POLL_GAP - 1);

    state_t      state_r, state_s;
    logic [1:0]  op_r;
    logic [31:0] period_r;
    logic [7:0]  cnt_r;
    logic [15:0] snap_lo_r;
    logic        idle_ready_r, wait_ready_r;
    logic        accept_s, load_cnt_s;
    logic        cs_s, wn_s;
    logic [2:0]  addr_s;
    logic [15:0] wd_s;
    logic [31:0] rsp_data_s;

    // Only a stop may interrupt a pending one-shot, so readiness in WAIT is qualified by the opcode.
    assign cmd_ready = idle_ready_r | (wait_ready_r & (cmd_op == 2'd2));

    // Next-state decision and the bus access belonging to the next state.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        cs_s       = 1'b0;
        wn_s       = 1'b1;
        addr_s     = 3'd0;
        wd_s       = 16'd0;
        rsp_data_s = 32'd0;
        case (state_r)
            S_IDLE, S_RESP: begin
                if (cmd_valid) begin
                    accept_s = 1'b1;
                    case (cmd_op)
                        2'd0, 2'd1: state_s = S_WR_PL;
                        2'd2:       state_s = S_WR_STOP;
                        default:    state_s = S_SN_WR;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR_PL:   state_s = S_WR_PH;
            S_WR_PH:   state_s = S_WR_CLR;
            S_WR_CLR:  state_s = S_WR_CTL;
            S_WR_CTL:  state_s = op_r[0] ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (cmd_valid && (cmd_op == 2'd2)) begin
                    accept_s = 1'b1;
                    state_s  = S_WR_STOP;
                end else if (irq || (cnt_r == 8'd0)) begin
                    state_s = S_RD_ST;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_RD_ST:   state_s = S_CAP_ST;
            S_CAP_ST:  state_s = readdata[0] ? S_WR_ACK : S_WAIT;
            S_WR_ACK:  state_s = S_RESP;
            S_WR_STOP: state_s = S_RESP;
            S_SN_WR:   state_s = S_SN_RDL;
            S_SN_RDL:  state_s = S_SN_RDH;
            S_SN_RDH:  state_s = S_SN_CAP;
            S_SN_CAP:  state_s = S_RESP;
            default:   state_s = S_IDLE;
        endcase

        // WR_PL is only reached on an accept, so the period comes straight from the command.
        case (state_s)
            S_WR_PL:   begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd2; wd_s = cmd_period[15:0]; end
            S_WR_PH:   begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd3; wd_s = period_r[31:16]; end
            S_WR_CLR:  begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd0; wd_s = 16'd0; end
            S_WR_CTL:  begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd1; wd_s = {13'd0, 1'b1, op_r[0], IRQ_EN}; end
            S_RD_ST:   begin cs_s = 1'b1; wn_s = 1'b1; addr_s = 3'd0; wd_s = 16'd0; end
            S_WR_ACK:  begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd0; wd_s = 16'd0; end
            S_WR_STOP: begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd1; wd_s = 16'h0008; end
            S_SN_WR:   begin cs_s = 1'b1; wn_s = 1'b0; addr_s = 3'd4; wd_s = 16'd0; end
            S_SN_RDL:  begin cs_s = 1'b1; wn_s = 1'b1; addr_s = 3'd4; wd_s = 16'd0; end
            S_SN_RDH:  begin cs_s = 1'b1; wn_s = 1'b1; addr_s = 3'd5; wd_s = 16'd0; end
            default:   begin cs_s = 1'b0; wn_s = 1'b1; addr_s = 3'd0; wd_s = 16'd0; end
        endcase

        case (op_r)
            2'd0, 2'd1: rsp_data_s = period_r;
            2'd3:       rsp_data_s = {readdata, snap_lo_r};
            default:    rsp_data_s = 32'd0;
        endcase
    end

    assign load_cnt_s = (state_s == S_WAIT) && (state_r != S_WAIT);

    // State, command latches, poll counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            op_r         <= 2'd0;
            period_r     <= 32'd0;
            cnt_r        <= 8'd0;
            snap_lo_r    <= 16'd0;
            idle_ready_r <= 1'b1;
            wait_ready_r <= 1'b0;
            chipselect   <= 1'b0;
            write_n      <= 1'b1;
            address      <= 3'd0;
            writedata    <= 16'd0;
            rsp_valid    <= 1'b0;
            rsp_data     <= 32'd0;
            rsp_timeout  <= 1'b0;
        end else begin
            state_r      <= state_s;
            idle_ready_r <= (state_s == S_IDLE) || (state_s == S_RESP);
            wait_ready_r <= (state_s == S_WAIT);
            chipselect   <= cs_s;
            write_n      <= wn_s;
            address      <= addr_s;
            writedata    <= wd_s;
            rsp_valid    <= (state_s == S_RESP);
            if (accept_s) begin
                op_r     <= cmd_op;
                period_r <= cmd_period;
            end
            if (load_cnt_s) begin
                cnt_r <= GAP_M1;
            end else if (state_r == S_WAIT) begin
                cnt_r <= cnt_r - 8'd1;
            end
            if (state_r == S_SN_RDH) begin
                snap_lo_r <= readdata;
            end
            if (state_s == S_RESP) begin
                rsp_data    <= rsp_data_s;
                rsp_timeout <= (state_r == S_WR_ACK);
            end
        end
    end

endmodule
